i2c_target_port: RTL and testbench

- Clocked I2C target (responder) for the same bus our I2C master drives.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address and ACKs it. Delivers written bytes to user logic and serves read bytes from user logic.
- Sits between the open-drain pads and a simple byte-stream user interface; no clock stretching.

---
 rtl/i2c_target_port.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_port.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, byte write/read user stream.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchronizer.
module i2c_target_port #(
    parameter logic [6:0] TARGET_ADDR = 7'b0101010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addressed,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // Line 0 is SCL, line 1 is SDA; both get identical conditioning so their relative timing is kept.
    logic [1:0] pad_raw;
    logic [1:0] line_cond;
    logic [1:0] line_prev;
    logic       sda_low_reg;

    assign pad_raw = {i2c_sda, i2c_scl};
    assign i2c_sda = sda_low_reg ? 1'b0 : 1'bz;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;
            logic filt;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
            logic [2:0] hist_reg;
            always_ff @(posedge clk) begin
                if (rst) hist_reg <= 3'b111;
                else     hist_reg <= {hist_reg[1:0], sync_reg};
            end
            assign filt = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) |
                          (hist_reg[1] & hist_reg[2]);
`else
            assign filt = sync_reg;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= pad_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= filt;
                end
            end
            assign line_cond[gi] = filt;
            assign line_prev[gi] = prev_reg;
        end
    endgenerate

    logic scl_rise, scl_fall, start_det, stop_det, sda_in;
    assign sda_in    = line_cond[1];
    assign scl_rise  = line_cond[0] & ~line_prev[0];
    assign scl_fall  = ~line_cond[0] & line_prev[0];
    assign start_det = line_cond[0] & line_prev[0] & ~line_cond[1] & line_prev[1];
    assign stop_det  = line_cond[0] & line_prev[0] & line_cond[1] & ~line_prev[1];

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rw_reg, rw_next;
    logic       ack_ok_reg, ack_ok_next;
    logic       sda_low_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_req_reg, tx_req_next;
    logic       addressed_reg, addressed_next;
    logic       busy_reg, busy_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            rx_data_reg   <= 8'd0;
            rw_reg        <= 1'b0;
            ack_ok_reg    <= 1'b0;
            sda_low_reg   <= 1'b0;
            rx_valid_reg  <= 1'b0;
            tx_req_reg    <= 1'b0;
            addressed_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            rx_data_reg   <= rx_data_next;
            rw_reg        <= rw_next;
            ack_ok_reg    <= ack_ok_next;
            sda_low_reg   <= sda_low_next;
            rx_valid_reg  <= rx_valid_next;
            tx_req_reg    <= tx_req_next;
            addressed_reg <= addressed_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        rx_data_next   = rx_data_reg;
        rw_next        = rw_reg;
        ack_ok_next    = ack_ok_reg;
        sda_low_next   = sda_low_reg;
        rx_valid_next  = 1'b0;
        tx_req_next    = 1'b0;
        addressed_next = addressed_reg;
        busy_next      = busy_reg;

        if (start_det) begin
            state_next     = ADDR;
            busy_next      = 1'b1;
            addressed_next = 1'b0;
            bit_cnt_next   = 3'd0;
            sda_low_next   = 1'b0;
            ack_ok_next    = 1'b0;
        end else if (stop_det) begin
            state_next     = IDLE;
            sda_low_next   = 1'b0;
            busy_next      = 1'b0;
            addressed_next = 1'b0;
        end else begin
            case (state_reg)
                ADDR: if (scl_rise) begin
                    shift_next   = {shift_reg[6:0], sda_in};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        rw_next = sda_in;
                        if (shift_reg[6:0] == TARGET_ADDR) begin
                            state_next  = ACK_ADDR;
                            tx_req_next = sda_in;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end
                end
                // First falling edge drives the ACK, the second ends the slot.
                ACK_ADDR, ACK_WR: if (scl_fall) begin
                    if (!sda_low_reg) begin
                        sda_low_next = 1'b1;
                        if (state_reg == ACK_ADDR) addressed_next = 1'b1;
                    end else if (state_reg == ACK_WR || !rw_reg) begin
                        sda_low_next = 1'b0;
                        state_next   = WR_DATA;
                    end else begin
                        shift_next   = tx_data;
                        sda_low_next = ~tx_data[7];
                        state_next   = RD_DATA;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_next   = {shift_reg[6:0], sda_in};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        rx_data_next  = {shift_reg[6:0], sda_in};
                        rx_valid_next = 1'b1;
                        state_next    = ACK_WR;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        sda_low_next = 1'b0;
                        ack_ok_next  = 1'b0;
                        state_next   = RD_ACK;
                    end else begin
                        shift_next   = {shift_reg[6:0], 1'b0};
                        sda_low_next = ~shift_reg[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_in) begin
                            ack_ok_next = 1'b1;
                            tx_req_next = 1'b1;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end else if (scl_fall && ack_ok_reg) begin
                        shift_next   = tx_data;
                        sda_low_next = ~tx_data[7];
                        ack_ok_next  = 1'b0;
                        state_next   = RD_DATA;
                    end
                end
                default: sda_low_next = 1'b0;
            endcase
        end
    end

    assign tx_req    = tx_req_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign addressed = addressed_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_target_port.sv
// Directed bench for i2c_target_port: bit-banged master with pull-up SDA and fixed expected values.
module tb_i2c_target_port;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       master_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req, rx_valid, addressed, busy;
    logic [7:0] rx_data;
    wire        sda_bus;

    assign sda_bus = master_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target_port dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_scl   (scl_drv),
        .i2c_sda   (sda_bus),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addressed (addressed),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int rxv_total = 0, txr_total = 0, drive_total = 0, busy_low_total = 0;

    // Running event counters; scenarios compare deltas of these.
    always @(negedge clk) begin
        if (rx_valid) rxv_total <= rxv_total + 1;
        if (tx_req) txr_total <= txr_total + 1;
        if (!rst && !master_low && sda_bus === 1'b0) drive_total <= drive_total + 1;
        if (!busy) busy_low_total <= busy_low_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        master_low = 1'b0;
        cyc(P);
        scl_drv = 1'b1;
        cyc(P);
        master_low = 1'b1;
        cyc(P);
        scl_drv = 1'b0;
        cyc(2);
    endtask

    task automatic bus_stop();
        cyc(2);
        master_low = 1'b1;
        cyc(P);
        scl_drv = 1'b1;
        cyc(P);
        master_low = 1'b0;
        cyc(P);
    endtask

    task automatic write_bit(input logic b, input bit glitch);
        cyc(2);
        master_low = ~b;
        cyc(P - 2);
        scl_drv = 1'b1;
        if (glitch) begin
            cyc(3);
            scl_drv = 1'b0;
            cyc(1);
            scl_drv = 1'b1;
            cyc(P - 4);
        end else begin
            cyc(P);
        end
        scl_drv = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        cyc(2);
        master_low = 1'b0;
        cyc(P - 2);
        scl_drv = 1'b1;
        cyc(P / 2);
        b = sda_bus;
        cyc(P / 2);
        scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == gbit);
        read_bit(ack);
    endtask

    task automatic read_bits8(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int         rxv0, txr0, drv0, bl0;

        cyc(4);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset tx_req", tx_req, 1'b0);
        check("reset addressed", addressed, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset sda", sda_bus, 1'b1);
        rst = 1'b0;
        cyc(4);

        // Write 0xAA to 0x2A
        rxv0 = rxv_total;
        bus_start();
        write_byte(8'h54, -1, ack);
        check("wr addr ack", ack, 1'b0);
        check("wr addressed", addressed, 1'b1);
        write_byte(8'hAA, -1, ack);
        check("wr data ack", ack, 1'b0);
        check("wr rx_data", rx_data, 8'hAA);
        check("wr busy", busy, 1'b1);
        bus_stop();
        check("wr rx_valid count", rxv_total - rxv0, 1);
        check("wr busy after stop", busy, 1'b0);
        check("wr addressed after stop", addressed, 1'b0);
        $display("txn: write 0x2A data 0xAA rx_data=0x%0h", rx_data);

        // Write to non-matching 0x15
        rxv0 = rxv_total;
        drv0 = drive_total;
        bus_start();
        write_byte(8'h2A, -1, ack);
        check("miss addr nack", ack, 1'b1);
        write_byte(8'h33, -1, ack);
        check("miss data nack", ack, 1'b1);
        check("miss busy", busy, 1'b1);
        check("miss addressed", addressed, 1'b0);
        check("miss rx_valid count", rxv_total - rxv0, 0);
        check("miss sda driven", drive_total - drv0, 0);
        bus_stop();
        check("miss busy after stop", busy, 1'b0);
        $display("txn: write 0x15 ignored");

        // Read 0x5C from 0x2A, master NACK
        tx_data = 8'h5C;
        txr0 = txr_total;
        bus_start();
        write_byte(8'h55, -1, ack);
        check("rd addr ack", ack, 1'b0);
        read_bits8(d);
        write_bit(1'b1, 1'b0);
        check("rd data", d, 8'h5C);
        check("rd tx_req count", txr_total - txr0, 1);
        cyc(6);
        check("rd sda released", sda_bus, 1'b1);
        check("rd addressed held", addressed, 1'b1);
        drv0 = drive_total;
        for (int i = 0; i < 9; i++) read_bit(b);
        check("rd wait_stop silent", drive_total - drv0, 0);
        check("rd busy before stop", busy, 1'b1);
        bus_stop();
        check("rd busy after stop", busy, 1'b0);
        $display("txn: read 0x2A data 0x%0h", d);

        // Two-byte read
        tx_data = 8'h81;
        txr0 = txr_total;
        bus_start();
        write_byte(8'h55, -1, ack);
        check("rd2 addr ack", ack, 1'b0);
        read_bits8(d);
        check("rd2 byte0", d, 8'h81);
        tx_data = 8'h3F;
        write_bit(1'b0, 1'b0);
        read_bits8(d);
        check("rd2 byte1", d, 8'h3F);
        write_bit(1'b1, 1'b0);
        check("rd2 tx_req count", txr_total - txr0, 2);
        bus_stop();
        $display("txn: read two bytes 0x81 0x%0h", d);

        // Write 0xF0 then repeated START as read of 0xC3
        tx_data = 8'hC3;
        rxv0 = rxv_total;
        bus_start();
        bl0 = busy_low_total;
        write_byte(8'h54, -1, ack);
        check("rs wr addr ack", ack, 1'b0);
        write_byte(8'hF0, -1, ack);
        check("rs wr data ack", ack, 1'b0);
        check("rs rx_data", rx_data, 8'hF0);
        check("rs rx_valid count", rxv_total - rxv0, 1);
        bus_start();
        check("rs addressed cleared", addressed, 1'b0);
        write_byte(8'h55, -1, ack);
        check("rs rd addr ack", ack, 1'b0);
        read_bits8(d);
        write_bit(1'b1, 1'b0);
        check("rs rd data", d, 8'hC3);
        check("rs busy never dropped", busy_low_total - bl0, 0);
        bus_stop();
        $display("txn: write 0xF0 + repeated-start read 0x%0h", d);

        // Reset while the target pulls SDA low
        tx_data = 8'h00;
        bus_start();
        write_byte(8'h55, -1, ack);
        read_bit(b);
        read_bit(b);
        cyc(4);
        check("mid-read sda driven", sda_bus, 1'b0);
        rst = 1'b1;
        cyc(1);
        check("rst sda released", sda_bus, 1'b1);
        check("rst rx_data", rx_data, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst addressed", addressed, 1'b0);
        check("rst tx_req", tx_req, 1'b0);
        check("rst rx_valid", rx_valid, 1'b0);
        rst = 1'b0;
        cyc(4);
        bus_stop();
        $display("txn: reset during read");

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        rxv0 = rxv_total;
        bus_start();
        write_byte(8'h54, -1, ack);
        check("gl addr ack", ack, 1'b0);
        write_byte(8'hA5, 4, ack);
        check("gl data ack", ack, 1'b0);
        check("gl rx_data", rx_data, 8'hA5);
        check("gl rx_valid count", rxv_total - rxv0, 1);
        bus_stop();
        $display("txn: write 0xA5 with SCL glitch rx_data=0x%0h", rx_data);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
